// File: rtl/fog_pkg.sv
// Shared types and constants for the FOG sample-capture block.
// Optional build macro: FOG_SAMPLE_TS_EN adds a per-frame 32-bit timestamp.
package fog_pkg;

  localparam int DECIM_LOG2_MAX = 10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC,
    S_PUSH
  } fog_cap_state_e;

  typedef struct packed {
    logic signed [31:0] err;
    logic signed [31:0] step;
    logic signed [31:0] ramp;
`ifdef FOG_SAMPLE_TS_EN
    logic [31:0]        ts;
`endif
  } fog_frame_t;

  localparam int FRAME_W = $bits(fog_frame_t);

  // Window exponents above the accumulator's guard range are clamped.
  function automatic logic [3:0] clamp_k(input logic [3:0] k);
    return (k > 4'(DECIM_LOG2_MAX)) ? 4'(DECIM_LOG2_MAX) : k;
  endfunction

endpackage

// File: rtl/fog_sync_fifo.sv
// Single-clock frame FIFO with registered read data and exact fill level.
// A write while full is accepted only when a read frees a slot in the same cycle.
module fog_sync_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             rd_ok;
  logic             wr_ok;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign level = count;
  assign rd_ok = rd_en && !empty;
  assign wr_ok = wr_en && (!full || rd_ok);

  // Storage array: data only, no reset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  // Pointers and level; pointers wrap naturally on the power-of-two depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Registered read port: data holds until the next accepted read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_ok;
      if (rd_ok) rd_data <= mem[rd_ptr];
    end
  end

endmodule

// File: rtl/fog_sample_capture_v1.sv
// FOG loop sample capture: averages i_err over 2^k triggers and queues
// {err_avg, step, ramp} frames for the CPU.
// Optional build macro: FOG_SAMPLE_TS_EN stores a cycle-count timestamp per frame.
module fog_sample_capture_v1
  import fog_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int ACC_W = 44
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_enable,
  input  logic                     i_trig,
  input  logic [3:0]               i_decim_log2,
  input  logic signed [31:0]       i_err,
  input  logic signed [31:0]       i_step,
  input  logic signed [31:0]       i_ramp,
  input  logic                     i_rd_req,
  input  logic                     i_clr_ovf,
  output logic                     o_rd_valid,
  output logic signed [31:0]       o_rd_err,
  output logic signed [31:0]       o_rd_step,
  output logic signed [31:0]       o_rd_ramp,
  output logic [31:0]              o_rd_ts,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_ovf
);

  // Clamp the shifted accumulator into the signed 32-bit range.
  function automatic logic signed [31:0] sat32(input logic signed [ACC_W-1:0] v);
    logic [ACC_W-32:0] hi;
    hi = v[ACC_W-1:31];
    if (&hi || ~|hi) return v[31:0];
    return v[ACC_W-1] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
  endfunction

  fog_cap_state_e           state_p0, state_nxt;
  logic [3:0]               k_p0, k_nxt;
  logic signed [ACC_W-1:0]  acc_p0, acc_nxt;
  logic [9:0]               cnt_p0, cnt_nxt;
  logic signed [31:0]       step_p0, step_nxt;
  logic signed [31:0]       ramp_p0, ramp_nxt;
  logic signed [ACC_W-1:0]  err_ext;
  logic [9:0]               win_max;
  logic                     push;
  logic                     ovf_evt;
  fog_frame_t               wr_frame;
  fog_frame_t               rd_frame;

  assign err_ext = ACC_W'(i_err);
  assign win_max = 10'((11'd1 << k_p0) - 11'd1);
  assign push    = (state_p0 == S_PUSH);

  // Next-state logic: window accumulation, frame hand-off, enable abort.
  always_comb begin
    state_nxt = state_p0;
    k_nxt     = k_p0;
    acc_nxt   = acc_p0;
    cnt_nxt   = cnt_p0;
    step_nxt  = step_p0;
    ramp_nxt  = ramp_p0;
    case (state_p0)
      S_IDLE: begin
        if (i_enable) begin
          state_nxt = S_ACC;
          k_nxt     = clamp_k(i_decim_log2);
          acc_nxt   = '0;
          cnt_nxt   = '0;
        end
      end
      S_ACC: begin
        if (i_trig) begin
          acc_nxt = acc_p0 + err_ext;
          cnt_nxt = cnt_p0 + 10'd1;
          if (cnt_p0 == win_max) begin
            state_nxt = S_PUSH;
            step_nxt  = i_step;
            ramp_nxt  = i_ramp;
          end
        end
      end
      S_PUSH: begin
        state_nxt = S_ACC;
        k_nxt     = clamp_k(i_decim_log2);
        acc_nxt   = '0;
        cnt_nxt   = '0;
        // A trigger here opens the next window; with k=0 it also closes it.
        if (i_trig) begin
          acc_nxt = err_ext;
          cnt_nxt = 10'd1;
          if (k_nxt == 4'd0) begin
            state_nxt = S_PUSH;
            step_nxt  = i_step;
            ramp_nxt  = i_ramp;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (!i_enable) begin
      state_nxt = S_IDLE;
      acc_nxt   = '0;
      cnt_nxt   = '0;
    end
  end

  // Stage p0 control registers: FSM, window exponent, accumulator, count.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_p0 <= S_IDLE;
      k_p0     <= '0;
      acc_p0   <= '0;
      cnt_p0   <= '0;
    end else begin
      state_p0 <= state_nxt;
      k_p0     <= k_nxt;
      acc_p0   <= acc_nxt;
      cnt_p0   <= cnt_nxt;
    end
  end

  // Stage p0 data registers: step/ramp captured on the window-closing trigger.
  always_ff @(posedge i_clk) begin
    step_p0 <= step_nxt;
    ramp_p0 <= ramp_nxt;
  end

`ifdef FOG_SAMPLE_TS_EN
  logic [31:0] ts_cnt;

  // Free-running cycle counter sampled into each frame.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) ts_cnt <= '0;
    else       ts_cnt <= ts_cnt + 32'd1;
  end

  assign wr_frame.ts = ts_cnt;
  assign o_rd_ts     = rd_frame.ts;
`else
  assign o_rd_ts = '0;
`endif

  assign wr_frame.err  = sat32(acc_p0 >>> k_p0);
  assign wr_frame.step = step_p0;
  assign wr_frame.ramp = ramp_p0;

  fog_sync_fifo #(
    .WIDTH (FRAME_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (i_clk),
    .rst      (i_rst),
    .wr_en    (push),
    .wr_data  (wr_frame),
    .rd_en    (i_rd_req),
    .rd_data  (rd_frame),
    .rd_valid (o_rd_valid),
    .full     (o_full),
    .empty    (o_empty),
    .level    (o_level)
  );

  assign o_rd_err  = rd_frame.err;
  assign o_rd_step = rd_frame.step;
  assign o_rd_ramp = rd_frame.ramp;

  // A push that finds the FIFO full with no read in the same cycle is dropped.
  assign ovf_evt = push && o_full && !(i_rd_req && !o_empty);

  // Sticky overflow flag; a coincident overflow wins over the clear.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)          o_ovf <= 1'b0;
    else if (ovf_evt)   o_ovf <= 1'b1;
    else if (i_clr_ovf) o_ovf <= 1'b0;
  end

endmodule

// File: tb/tb_fog_sample_capture_v1.sv
// Scoreboard bench for fog_sample_capture_v1: stimulus pushes expected frames,
// a negedge monitor pops and compares whenever o_rd_valid is high.
module tb_fog_sample_capture_v1;

  logic               i_clk = 1'b0;
  logic               i_rst = 1'b0;
  logic               i_enable = 1'b0;
  logic               i_trig = 1'b0;
  logic [3:0]         i_decim_log2 = 4'd0;
  logic signed [31:0] i_err = '0;
  logic signed [31:0] i_step = '0;
  logic signed [31:0] i_ramp = '0;
  logic               i_rd_req = 1'b0;
  logic               i_clr_ovf = 1'b0;
  logic               o_rd_valid;
  logic signed [31:0] o_rd_err;
  logic signed [31:0] o_rd_step;
  logic signed [31:0] o_rd_ramp;
  logic [31:0]        o_rd_ts;
  logic               o_empty;
  logic               o_full;
  logic [4:0]         o_level;
  logic               o_ovf;

  fog_sample_capture_v1 #(.DEPTH(16), .ACC_W(44)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_enable     (i_enable),
    .i_trig       (i_trig),
    .i_decim_log2 (i_decim_log2),
    .i_err        (i_err),
    .i_step       (i_step),
    .i_ramp       (i_ramp),
    .i_rd_req     (i_rd_req),
    .i_clr_ovf    (i_clr_ovf),
    .o_rd_valid   (o_rd_valid),
    .o_rd_err     (o_rd_err),
    .o_rd_step    (o_rd_step),
    .o_rd_ramp    (o_rd_ramp),
    .o_rd_ts      (o_rd_ts),
    .o_empty      (o_empty),
    .o_full       (o_full),
    .o_level      (o_level),
    .o_ovf        (o_ovf)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] err;
    logic [31:0] step;
    logic [31:0] ramp;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [31:0] e, input logic [31:0] s, input logic [31:0] r);
    exp_t x;
    x.err  = e;
    x.step = s;
    x.ramp = r;
    exp_q.push_back(x);
  endtask

  // Advance n clock edges, ending 1 time unit after the last one.
  task automatic cyc(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic trig(input logic [31:0] e, input logic [31:0] s, input logic [31:0] r);
    i_trig = 1'b1;
    i_err  = e;
    i_step = s;
    i_ramp = r;
    cyc(1);
    i_trig = 1'b0;
  endtask

  task automatic rd1();
    i_rd_req = 1'b1;
    cyc(1);
    i_rd_req = 1'b0;
  endtask

  task automatic set_k(input logic [3:0] k);
    i_enable = 1'b0;
    cyc(1);
    i_decim_log2 = k;
    i_enable = 1'b1;
    cyc(1);
  endtask

  // Monitor: every presented read frame must match the oldest expected frame.
  always @(negedge i_clk) begin
    if (o_rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_rd_valid: got err 0x%08h, expected no read data", o_rd_err);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rd_err",  o_rd_err,  e.err);
        chk("rd_step", o_rd_step, e.step);
        chk("rd_ramp", o_rd_ramp, e.ramp);
`ifndef FOG_SAMPLE_TS_EN
        chk("rd_ts_zero", o_rd_ts, 32'd0);
`endif
      end
    end
  end

  initial begin
    // Reset state
    #1 i_rst = 1'b1;
    #1;
    chk("rst_empty", 32'(o_empty), 32'd1);
    chk("rst_level", 32'(o_level), 32'd0);
    chk("rst_full",  32'(o_full),  32'd0);
    chk("rst_ovf",   32'(o_ovf),   32'd0);
    chk("rst_valid", 32'(o_rd_valid), 32'd0);
    chk("rst_rd_err", o_rd_err, 32'd0);
    cyc(2);
    i_decim_log2 = 4'd2;
    i_enable = 1'b1;
    i_rst = 1'b0;
    cyc(1);

    // k=2: 10,20,30,40 -> 25, step/ramp from the 4th trigger
    trig(32'd10, 32'd1, 32'd2);
    trig(32'd20, 32'd3, 32'd4);
    trig(32'd30, 32'd5, 32'd6);
    trig(32'd40, 32'h111, 32'h222);
    chk("lat_empty_t1", 32'(o_empty), 32'd1);
    cyc(1);
    chk("lat_empty_t2", 32'(o_empty), 32'd0);
    chk("lat_level_t2", 32'(o_level), 32'd1);
    push_exp(32'd25, 32'h111, 32'h222);
    rd1();
    cyc(3);
    chk("rd_hold_err", o_rd_err, 32'd25);
    chk("rd_valid_one_cycle", 32'(o_rd_valid), 32'd0);
    rd1();
    chk("empty_rd_no_valid", 32'(o_rd_valid), 32'd0);
    cyc(1);

    // k=1 floor, k=0 passthrough of extremes
    set_k(4'd1);
    trig(-32'sd3, 32'd7, 32'd8);
    trig(-32'sd4, 32'd9, 32'd10);
    push_exp(-32'sd4, 32'd9, 32'd10);
    cyc(2);
    set_k(4'd0);
    trig(32'h7FFF_FFFF, 32'd11, 32'd12);
    push_exp(32'h7FFF_FFFF, 32'd11, 32'd12);
    cyc(1);
    trig(32'h8000_0000, 32'd13, 32'd14);
    push_exp(32'h8000_0000, 32'd13, 32'd14);
    cyc(2);
    chk("level_three", 32'(o_level), 32'd3);
    for (int i = 0; i < 3; i++) begin
      rd1();
      cyc(1);
    end
    chk("drained_empty", 32'(o_empty), 32'd1);

    // k=0, 17 back-to-back triggers: 16 stored, 17th dropped
    for (int i = 1; i <= 17; i++) begin
      i_trig = 1'b1;
      i_err  = 32'(i * 100);
      i_step = 32'(i);
      i_ramp = -32'(i);
      if (i <= 16) push_exp(32'(i * 100), 32'(i), -32'(i));
      cyc(1);
    end
    i_trig = 1'b0;
    cyc(3);
    chk("ovf_full",  32'(o_full),  32'd1);
    chk("ovf_level", 32'(o_level), 32'd16);
    chk("ovf_set",   32'(o_ovf),   32'd1);
    i_clr_ovf = 1'b1;
    cyc(1);
    i_clr_ovf = 1'b0;
    chk("ovf_cleared", 32'(o_ovf), 32'd0);

    // Full: push and read in the same cycle
    trig(32'd500, 32'd50, 32'd60);
    i_rd_req = 1'b1;
    cyc(1);
    i_rd_req = 1'b0;
    push_exp(32'd500, 32'd50, 32'd60);
    cyc(1);
    chk("simul_level", 32'(o_level), 32'd16);
    chk("simul_ovf",   32'(o_ovf),   32'd0);
    chk("simul_full",  32'(o_full),  32'd1);

    // Full: overflow coincident with clear keeps the flag set
    trig(32'd999, 32'd99, 32'd98);
    i_clr_ovf = 1'b1;
    cyc(1);
    i_clr_ovf = 1'b0;
    chk("ovf_clr_coincide", 32'(o_ovf), 32'd1);
    chk("ovf_drop_level", 32'(o_level), 32'd16);
    i_clr_ovf = 1'b1;
    cyc(1);
    i_clr_ovf = 1'b0;
    chk("ovf_cleared2", 32'(o_ovf), 32'd0);
    for (int i = 0; i < 16; i++) begin
      rd1();
      cyc(1);
    end
    chk("drain16_empty", 32'(o_empty), 32'd1);
    chk("drain16_level", 32'(o_level), 32'd0);

    // Enable dropped mid-window: partial window discarded
    set_k(4'd2);
    trig(32'd1000, 32'd1, 32'd1);
    trig(32'd1000, 32'd1, 32'd1);
    trig(32'd1000, 32'd1, 32'd1);
    i_enable = 1'b0;
    cyc(2);
    i_enable = 1'b1;
    cyc(1);
    chk("abort_no_frame", 32'(o_level), 32'd0);
    trig(32'd1, 32'd0, 32'd0);
    trig(32'd2, 32'd0, 32'd0);
    trig(32'd3, 32'd0, 32'd0);
    trig(32'd4, 32'hA, 32'hB);
    push_exp(32'd2, 32'hA, 32'hB);
    cyc(2);
    chk("fresh_level", 32'(o_level), 32'd1);
    rd1();
    cyc(2);

    // Five stored frames, reset mid-window during a read
    for (int i = 0; i < 22; i++) trig(32'(i), 32'(i), 32'(i));
    cyc(2);
    chk("pre_rst_level", 32'(o_level), 32'd5);
    i_rd_req = 1'b1;
    @(posedge i_clk);
    #2;
    i_rst = 1'b1;
    i_rd_req = 1'b0;
    #1;
    chk("mid_rst_level", 32'(o_level), 32'd0);
    chk("mid_rst_empty", 32'(o_empty), 32'd1);
    chk("mid_rst_valid", 32'(o_rd_valid), 32'd0);
    chk("mid_rst_ovf",   32'(o_ovf),   32'd0);
    #1;
    i_rst = 1'b0;
    cyc(1);
    trig(-32'sd8, 32'd0, 32'd0);
    trig(-32'sd8, 32'd0, 32'd0);
    trig(-32'sd8, 32'd0, 32'd0);
    trig(-32'sd9, 32'h5, 32'h6);
    push_exp(-32'sd9, 32'h5, 32'h6);
    cyc(2);
    chk("post_rst_level", 32'(o_level), 32'd1);
    rd1();
    cyc(3);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
